led_event_monitor: RTL
======================

# led_event_monitor

Observer for an 8-bit LED status bus driven by a counter-based LED block. Samples `led` every clock, detects value changes, and queues each change as a timestamped event in a small FIFO. Events drain through a valid/ready handshake to a debug or host interface. Counts and flags events lost to FIFO overflow.

## Interface
- `WIDTH`, 8: width of observed `led` bus and `ev_data`
- `TS_WIDTH`, 16: width of free-running timestamp and `ev_time`
- `DEPTH`, 4: FIFO entries; power of two, ≥2

- `CLK` input 1: single clock, all logic on rising edge
- `RST` input 1: asynchronous, active-low reset
- `led` input WIDTH: observed LED bus, synchronous to `CLK`
- `enable` input 1: monitoring enable; low = no events captured
- `ev_valid` output 1: FIFO head holds an event
- `ev_ready` input 1: consumer accepts head event
- `ev_data` output WIDTH: new `led` value of head event
- `ev_time` output TS_WIDTH: timestamp of head event
- `overflow` output 1: sticky, set when any event is dropped
- `drop_cnt` output 8: dropped-event count, saturates at 255
- `clear_ovf` input 1: synchronous clear of `overflow` and `drop_cnt`

## Operation
- Reset (`RST`=0, async): `ts`=0, `led_q`=0, FIFO empty, `ev_valid`=0, `ev_data`=0, `ev_time`=0, `overflow`=0, `drop_cnt`=0, state=PRIME.
- `ts` increments by 1 every cycle after reset release and wraps from 2^TS_WIDTH−1 to 0 with no flag.
- `led_q` loads `led` every cycle in every state.
- State PRIME: no change detection. Captures baseline. Goes to RUN on the next edge if `enable`=1, otherwise stays.
- State RUN: change = (`led` != `led_q`) at an edge. Goes to PRIME on any edge with `enable`=0. No event is generated on that edge.
- On a change, push {`led`, `ts`} (current pre-increment values) into the FIFO.
- Full FIFO with no pop in the same cycle: event is dropped, `overflow`←1, `drop_cnt`←min(`drop_cnt`+1, 255).
- Pop when `ev_valid`&&`ev_ready`.
- Simultaneous push and pop when full: both happen, no drop.
- Simultaneous push and pop when empty: push only; `ev_valid` was 0, so no pop.
- `ev_data`/`ev_time` are driven from the FIFO head. They are 0 when empty and must stay stable while `ev_valid`=1 and `ev_ready`=0.
- `clear_ovf`=1 clears `overflow` and `drop_cnt`. A drop in the same cycle wins: `overflow`=1, `drop_cnt`=1.
- Consecutive-cycle changes each produce a separate event. No debounce.

## Timing
- Change present at edge k (RUN): event enters FIFO at edge k. If FIFO was empty, `ev_valid`=1 from edge k; `ev_time` = `ts` sampled at edge k.
- First edge after reset release: `ts` captured as 0, state PRIME. Earliest possible event is at edge 2 with `ts`=1, given `enable`=1 throughout.
- Pop at edge k: next entry is presented from edge k; `ev_valid` drops at edge k if that was the last entry.
- Throughput: one push and one pop per cycle.
- `enable` re-asserted after being low: one PRIME cycle. A `led` change on that edge is absorbed into the baseline.
- `RST` asserted mid-operation: FIFO contents discarded immediately, all outputs return to reset values asynchronously.

## Test plan
- Reset release, `enable`=1, `ev_ready`=1, `led` 0x00→0x05 at edge 5 → one event `ev_data`=0x05, `ev_time`=4, `ev_valid` high one cycle.
- `ev_ready`=0, 5 changes on consecutive cycles (0x01..0x05), DEPTH=4 → FIFO holds 0x01..0x04, `overflow`=1, `drop_cnt`=1. Head stable at 0x01 until `ev_ready`=1, then drains in order in 4 cycles.
- FIFO full, change and `ev_ready`=1 on the same edge → no drop, `drop_cnt` unchanged, 4 entries remain.
- `enable` low for 3 cycles while `led` toggles, re-asserted together with `led`=0xAA → no events. A later change to 0xAB yields exactly one event 0xAB.
- 300 drops with `ev_ready`=0 → `drop_cnt`=255. `clear_ovf` pulse → `overflow`=0, `drop_cnt`=0.
- `ts` near wrap (run 65535 cycles), change at `ts`=0xFFFF and at the next edge → `ev_time` 0xFFFF then 0x0000. Assert `RST` with 2 queued events → `ev_valid`=0 immediately, no events after release until a new change.

Source files
------------

// File: rtl/led_event_monitor.sv
// Watches an LED status bus, turns every value change into a timestamped event,
// and buffers events in a small FIFO drained by a valid/ready consumer.
module led_event_monitor #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [WIDTH-1:0]    led,
    input  logic                enable,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [WIDTH-1:0]    ev_data,
    output logic [TS_WIDTH-1:0] ev_time,
    output logic                overflow,
    output logic [7:0]          drop_cnt,
    input  logic                clear_ovf,
    output logic                dbg_state
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                     state, state_nxt;
    logic [TS_WIDTH-1:0]        ts;
    logic [WIDTH-1:0]           led_q;
    logic [WIDTH+TS_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count;

    logic change, full, pop, do_push, drop;

    // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
    // ev_data/ev_time hold steady while ev_valid is high and ev_ready is low.
    assign ev_valid  = (count != '0);
    assign ev_data   = ev_valid ? mem[rd_ptr][WIDTH+TS_WIDTH-1:TS_WIDTH] : '0;
    assign ev_time   = ev_valid ? mem[rd_ptr][TS_WIDTH-1:0] : '0;
    assign dbg_state = (state == RUN);

    // Deasserting enable costs the change on that edge; PRIME rebuilds the baseline.
    assign change  = (state == RUN) && enable && (led != led_q);
    assign full    = (count == DEPTH_C);
    assign pop     = ev_valid && ev_ready;
    assign do_push = change && (!full || pop);
    assign drop    = change && full && !pop;

    always_comb begin
        state_nxt = state;
        case (state)
            PRIME:   state_nxt = enable ? RUN : PRIME;
            RUN:     state_nxt = enable ? RUN : PRIME;
            default: state_nxt = PRIME;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= PRIME;
            ts    <= '0;
            led_q <= '0;
        end else begin
            state <= state_nxt;
            ts    <= ts + 1'b1;
            led_q <= led;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {led, ts};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (!do_push && pop) count <= count - 1'b1;
        end
    end

    // A drop on the same edge as clear_ovf counts as the first drop after the clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf)               drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule
